cache_set_lookup_exec: RTL

- Execution stage directly downstream of the cache operation controller.
- Consumes its two phase pulses:
  - opr_1_pulse starts a serial 4-way tag lookup on the captured address.
  - opr_2_pulse commits the result: PLRU update, plus fill/eviction on a miss.
- Returns a one-cycle opr_finished pulse to the controller, which clears its operation counter.
- Holds the tag/valid/dirty store and 4-way tree-PLRU state for one cache level.

---
 rtl/cache_set_lookup_exec_if.sv | 40 ++++
 rtl/cache_set_lookup_exec.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_set_lookup_exec_if.sv
`default_nettype none
// ============================================================================
// cache_set_lookup_exec_if : controller <-> lookup/commit stage handshake bus
// Revision : 1.0
// ============================================================================
interface cache_set_lookup_exec_if #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int SETS     = 16
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

  logic [ADDR_W-1:0] addr;
  logic              is_write;
  logic              opr_1_pulse;
  logic              opr_2_pulse;
  logic              opr_finished;
  logic              busy;
  logic              hit;
  logic [1:0]        hit_way;
  logic [1:0]        victim_way;
  logic              evict_valid;
  logic              evict_dirty;
  logic [TAG_W-1:0]  evict_tag;
  logic              proto_err;

  modport master (
    output addr, is_write, opr_1_pulse, opr_2_pulse,
    input  opr_finished, busy, hit, hit_way, victim_way,
           evict_valid, evict_dirty, evict_tag, proto_err
  );

  modport slave (
    input  addr, is_write, opr_1_pulse, opr_2_pulse,
    output opr_finished, busy, hit, hit_way, victim_way,
           evict_valid, evict_dirty, evict_tag, proto_err
  );
endinterface
`default_nettype wire

// File: rtl/cache_set_lookup_exec.sv
`default_nettype none
// ============================================================================
// cache_set_lookup_exec : serial 4-way tag lookup, PLRU update and miss fill
// Revision : 1.0
// ============================================================================
module cache_set_lookup_exec #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int SETS     = 16
) (
  input  logic                   clk,
  input  logic                   rstb,
  cache_set_lookup_exec_if.slave bus
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Tree PLRU: b0 picks the half, b1/b2 pick within the lower/upper half.
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    if (!b[0]) return b[1] ? 2'd1 : 2'd0;
    return b[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] n;
    n = b;
    case (w)
      2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  state_t             r_state;
  logic [1:0]         r_way_ptr;
  logic [INDEX_W-1:0] r_index;
  logic [TAG_W-1:0]   r_tag;
  logic               r_is_write;
  logic               r_pend;
  logic               r_hit;
  logic [1:0]         r_hit_way;
  logic               r_inv_found;
  logic [1:0]         r_inv_way;
  logic [1:0]         r_victim_way;
  logic               r_evict_valid;
  logic               r_evict_dirty;
  logic [TAG_W-1:0]   r_evict_tag;
  logic               r_finished;
  logic               r_busy;
  logic               r_proto_err;

  logic [TAG_W-1:0]   r_tags  [SETS][4];
  logic [3:0]         r_valid [SETS];
  logic [3:0]         r_dirty [SETS];
  logic [2:0]         r_plru  [SETS];

  logic [INDEX_W-1:0] w_req_index;
  logic [TAG_W-1:0]   w_req_tag;
  logic               w_unused_offset;
  logic               w_cur_valid;
  logic               w_match;
  logic               w_inv_any;
  logic [1:0]         w_inv_sel;
  logic [1:0]         w_victim;
  logic [1:0]         w_upd_way;
  logic               w_proto_viol;

  assign w_req_index     = bus.addr[OFFSET_W +: INDEX_W];
  assign w_req_tag       = bus.addr[ADDR_W-1 -: TAG_W];
  assign w_unused_offset = ^bus.addr[OFFSET_W-1:0];

  assign w_cur_valid = r_valid[r_index][r_way_ptr];
  assign w_match     = w_cur_valid && (r_tags[r_index][r_way_ptr] == r_tag);

  // Invalid-way tracking includes the way being examined this cycle, so the
  // victim can be frozen on the last lookup cycle.
  assign w_inv_any = r_inv_found || !w_cur_valid;
  assign w_inv_sel = r_inv_found ? r_inv_way : r_way_ptr;
  assign w_victim  = w_inv_any ? w_inv_sel : plru_victim(r_plru[r_index]);
  assign w_upd_way = r_hit ? r_hit_way : r_victim_way;

  assign w_proto_viol =
      (bus.opr_1_pulse && (r_state != S_IDLE)) ||
      (bus.opr_2_pulse && ((r_state == S_IDLE) || (r_state == S_UPDATE) ||
                           (r_state == S_DONE) ||
                           ((r_state == S_LOOKUP) && r_pend)));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state       <= S_IDLE;
      r_way_ptr     <= 2'd0;
      r_index       <= '0;
      r_tag         <= '0;
      r_is_write    <= 1'b0;
      r_pend        <= 1'b0;
      r_hit         <= 1'b0;
      r_hit_way     <= 2'd0;
      r_inv_found   <= 1'b0;
      r_inv_way     <= 2'd0;
      r_victim_way  <= 2'd0;
      r_evict_valid <= 1'b0;
      r_evict_dirty <= 1'b0;
      r_evict_tag   <= '0;
      r_finished    <= 1'b0;
      r_busy        <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      r_finished <= 1'b0;
      if (w_proto_viol) r_proto_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.opr_1_pulse) begin
            r_index       <= w_req_index;
            r_tag         <= w_req_tag;
            r_is_write    <= bus.is_write;
            r_way_ptr     <= 2'd0;
            r_pend        <= 1'b0;
            r_hit         <= 1'b0;
            r_hit_way     <= 2'd0;
            r_inv_found   <= 1'b0;
            r_inv_way     <= 2'd0;
            r_victim_way  <= 2'd0;
            r_evict_valid <= 1'b0;
            r_evict_dirty <= 1'b0;
            r_evict_tag   <= '0;
            r_busy        <= 1'b1;
            r_state       <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_match && !r_hit) begin
            r_hit     <= 1'b1;
            r_hit_way <= r_way_ptr;
          end
          if (!w_cur_valid && !r_inv_found) begin
            r_inv_found <= 1'b1;
            r_inv_way   <= r_way_ptr;
          end
          if (bus.opr_2_pulse) r_pend <= 1'b1;
          r_way_ptr <= r_way_ptr + 2'd1;
          if (r_way_ptr == 2'd3) begin
            r_victim_way <= w_victim;
            r_state      <= (r_pend || bus.opr_2_pulse) ? S_UPDATE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.opr_2_pulse) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_pend <= 1'b0;
          if (!r_hit) begin
            r_evict_valid <= r_valid[r_index][r_victim_way];
            r_evict_dirty <= r_valid[r_index][r_victim_way] &&
                             r_dirty[r_index][r_victim_way];
            r_evict_tag   <= r_valid[r_index][r_victim_way] ?
                             r_tags[r_index][r_victim_way] : '0;
          end
          r_finished <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // State arrays change only in UPDATE, so an aborting reset leaves nothing half-written.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= 4'd0;
        r_dirty[s] <= 4'd0;
        r_plru[s]  <= 3'd0;
      end
    end else if (r_state == S_UPDATE) begin
      r_valid[r_index][w_upd_way] <= 1'b1;
      r_dirty[r_index][w_upd_way] <= r_hit ? (r_dirty[r_index][w_upd_way] | r_is_write)
                                           : r_is_write;
      r_plru[r_index]             <= plru_touch(r_plru[r_index], w_upd_way);
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_UPDATE) && !r_hit) begin
      r_tags[r_index][r_victim_way] <= r_tag;
    end
  end

  assign bus.opr_finished = r_finished;
  assign bus.busy         = r_busy;
  assign bus.hit          = r_hit;
  assign bus.hit_way      = r_hit_way;
  assign bus.victim_way   = r_victim_way;
  assign bus.evict_valid  = r_evict_valid;
  assign bus.evict_dirty  = r_evict_dirty;
  assign bus.evict_tag    = r_evict_tag;
  assign bus.proto_err    = r_proto_err;

endmodule
`default_nettype wire
